contador_regresivo: RTL and testbench
=====================================

CONTADOR_REGRESIVO -- requirements
Module: contador_regresivo

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100_000_000, clock cycles per one-second tick.
REQ-002 SHALL have parameter ALARMA_S, default 3, alarm duration in seconds.
REQ-003 SHALL have port clk  input  1  single system clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port num  input  5  preset seconds from the cooking-program time selector.
REQ-006 SHALL have port start  input  1  one-cycle start/resume request.
REQ-007 SHALL have port pausa  input  1  one-cycle pause request.
REQ-008 SHALL have port cancelar  input  1  one-cycle abort request.
REQ-009 SHALL have port restante  output  5  seconds remaining.
REQ-010 SHALL have port calentando  output  1  heater enable, high only while counting.
REQ-011 SHALL have port alarma  output  1  end-of-cycle buzzer enable.
REQ-012 SHALL have port fin  output  1  one-cycle pulse on reaching zero.
REQ-013 SHALL have port estado  output  2  current state encoding.

Function
REQ-014 SHALL implement states REPOSO=0, CONTANDO=1, PAUSA=2, FIN=3, all outputs registered.
REQ-015 SHALL use an internal prescaler counting 0..CLK_HZ-1; tick asserted for one cycle when prescaler equals CLK_HZ-1, then it wraps to 0.
REQ-016 Prescaler SHALL run only in CONTANDO and FIN, hold its value in PAUSA, and clear to 0 in REPOSO.
REQ-017 REPOSO + start with num!=0: SHALL sample num into restante and enter CONTANDO on the same edge.
REQ-018 REPOSO + start with num==0: SHALL be ignored; stays REPOSO, fin not pulsed.
REQ-019 CONTANDO + tick: restante SHALL decrement by 1; if restante was 1, SHALL become 0, enter FIN, and pulse fin for exactly one cycle.
REQ-020 CONTANDO + pausa: SHALL enter PAUSA; restante and prescaler held.
REQ-021 PAUSA + start: SHALL return to CONTANDO, resuming the partial second (no prescaler clear).
REQ-022 FIN: alarma SHALL be high for ALARMA_S ticks, measured from prescaler cleared on FIN entry; then SHALL enter REPOSO with alarma low.
REQ-023 start and pausa in FIN SHALL be ignored; start in CONTANDO and pausa in PAUSA/REPOSO SHALL be ignored.
REQ-024 cancelar in any state SHALL enter REPOSO next edge, restante=0, alarma=0, no fin pulse.
REQ-025 Simultaneous-event priority SHALL be cancelar > pausa > start > tick; a tick coinciding with a winning pausa SHALL NOT decrement.
REQ-026 calentando SHALL equal (estado==CONTANDO); num changes outside a REPOSO start SHALL have no effect.

Reset
REQ-027 rst_n low SHALL asynchronously force estado=REPOSO, restante=0, calentando=0, alarma=0, fin=0, prescaler=0.
REQ-028 Reset mid-count SHALL discard the cycle; after release the block SHALL wait in REPOSO for start.

Structure
REQ-029 State encoding and NUM_W=5 SHALL live in shared package microondas_pkg.
REQ-030 Prescaler SHALL be sub-module divisor_1hz (inputs clk, rst_n, en, clr; output tick), parameterised by CLK_HZ.

Verification (CLK_HZ=4, ALARMA_S=3)
REQ-031 start with num=5 -> calentando high next edge; restante 5,4,3,2,1,0 every 4 cycles; fin pulse with restante=0; alarma high 12 cycles; then REPOSO.
REQ-032 start with num=0 -> estado stays 0, no fin, calentando never high.
REQ-033 pausa 2 cycles into second with restante=3, hold 10 cycles, start -> restante stays 3 during PAUSA; 2->... decrements 2 cycles after resume.
REQ-034 cancelar at restante=2 -> next edge estado=0, restante=0, calentando=0, no fin.
REQ-035 start, pausa, cancelar asserted together in CONTANDO -> REPOSO; pausa+tick together -> PAUSA, restante unchanged.
REQ-036 rst_n low mid-count, between clock edges -> all outputs 0 immediately, before next clk edge.

Source files
------------

// File: rtl/microondas_pkg.sv
// Shared definitions for the microwave countdown timer.
// Holds the state encoding exposed on the estado output and the width
// of the seconds field used by num and restante.
package microondas_pkg;

    localparam int NUM_W = 5;

    typedef enum logic [1:0] {
        REPOSO   = 2'd0,
        CONTANDO = 2'd1,
        PAUSA    = 2'd2,
        FIN      = 2'd3
    } estado_t;

endpackage

// File: rtl/contador_regresivo_if.sv
// Control/status bundle of the countdown timer.
//   master: drives num/start/pausa/cancelar, observes the status outputs
//   slave : the timer itself
//   num        preset seconds from the program selector
//   start      one-cycle start/resume request
//   pausa      one-cycle pause request
//   cancelar   one-cycle abort request
//   restante   seconds remaining
//   calentando heater enable
//   alarma     buzzer enable
//   fin        one-cycle pulse on reaching zero
//   estado     current state encoding
interface contador_regresivo_if;
    import microondas_pkg::*;

    logic [NUM_W-1:0] num;
    logic             start;
    logic             pausa;
    logic             cancelar;
    logic [NUM_W-1:0] restante;
    logic             calentando;
    logic             alarma;
    logic             fin;
    logic [1:0]       estado;

    modport master (
        output num, start, pausa, cancelar,
        input  restante, calentando, alarma, fin, estado
    );

    modport slave (
        input  num, start, pausa, cancelar,
        output restante, calentando, alarma, fin, estado
    );

endinterface

// File: rtl/divisor_1hz.sv
// One-second prescaler. Counts 0..CLK_HZ-1 while enabled and raises tick
// for the cycle in which it sits at CLK_HZ-1; clr has priority over en.
//   clk, rst_n : system clock, async active-low reset
//   en         : advance the count this cycle
//   clr        : force the count back to 0
//   tick       : one-second strobe (only while en)
module divisor_1hz #(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CW-1:0] MAX = CW'(CLK_HZ - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = en && (cnt_q == MAX);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/contador_regresivo.sv
// Microwave cooking countdown timer with pause, abort and end-of-cycle alarm.
//   clk, rst_n : system clock, async active-low reset
//   bus        : control requests in, status outputs out (all registered)
//
// state    | meaning
// REPOSO   | idle, waiting for start with a non-zero preset
// CONTANDO | heater on, restante decrements once per second
// PAUSA    | heater off, restante and partial second frozen
// FIN      | reached zero, buzzer on for ALARMA_S seconds
module contador_regresivo
    import microondas_pkg::*;
#(
    parameter int CLK_HZ   = 100_000_000,
    parameter int ALARMA_S = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    contador_regresivo_if.slave bus
);

    localparam int AW = ($clog2(ALARMA_S + 1) < 1) ? 1 : $clog2(ALARMA_S + 1);

    estado_t          estado_q, estado_d;
    logic [NUM_W-1:0] restante_q, restante_d;
    logic             calentando_q, calentando_d;
    logic             alarma_q, alarma_d;
    logic             fin_q, fin_d;
    logic [AW-1:0]    alarma_cnt_q, alarma_cnt_d;

    logic tick;
    logic pre_en;
    logic pre_clr;

    // A winning pausa freezes the prescaler on the same edge, so a
    // coinciding tick never reaches the FSM.
    assign pre_en = !bus.cancelar &&
                    (((estado_q == CONTANDO) && !bus.pausa) || (estado_q == FIN));

    // Restart the second on FIN entry so the alarm lasts whole seconds.
    assign pre_clr = bus.cancelar || (estado_q == REPOSO) ||
                     ((estado_q == CONTANDO) && !bus.pausa && tick &&
                      (restante_q == NUM_W'(1)));

    divisor_1hz #(.CLK_HZ(CLK_HZ)) u_divisor (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (pre_en),
        .clr  (pre_clr),
        .tick (tick)
    );

    always_comb begin
        estado_d     = estado_q;
        restante_d   = restante_q;
        alarma_d     = alarma_q;
        alarma_cnt_d = alarma_cnt_q;
        fin_d        = 1'b0;
        if (bus.cancelar) begin
            estado_d     = REPOSO;
            restante_d   = '0;
            alarma_d     = 1'b0;
            alarma_cnt_d = '0;
        end else begin
            case (estado_q)
                REPOSO: begin
                    if (bus.start && (bus.num != '0)) begin
                        estado_d   = CONTANDO;
                        restante_d = bus.num;
                    end
                end
                CONTANDO: begin
                    if (bus.pausa) begin
                        estado_d = PAUSA;
                    end else if (tick) begin
                        restante_d = restante_q - NUM_W'(1);
                        if (restante_q == NUM_W'(1)) begin
                            estado_d     = FIN;
                            fin_d        = 1'b1;
                            alarma_d     = 1'b1;
                            alarma_cnt_d = AW'(ALARMA_S);
                        end
                    end
                end
                PAUSA: begin
                    if (bus.start) begin
                        estado_d = CONTANDO;
                    end
                end
                FIN: begin
                    if (tick) begin
                        if (alarma_cnt_q == AW'(1)) begin
                            estado_d     = REPOSO;
                            alarma_d     = 1'b0;
                            alarma_cnt_d = '0;
                        end else begin
                            alarma_cnt_d = alarma_cnt_q - AW'(1);
                        end
                    end
                end
                default: estado_d = REPOSO;
            endcase
        end
        calentando_d = (estado_d == CONTANDO);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q     <= REPOSO;
            restante_q   <= '0;
            calentando_q <= 1'b0;
            alarma_q     <= 1'b0;
            fin_q        <= 1'b0;
            alarma_cnt_q <= '0;
        end else begin
            estado_q     <= estado_d;
            restante_q   <= restante_d;
            calentando_q <= calentando_d;
            alarma_q     <= alarma_d;
            fin_q        <= fin_d;
            alarma_cnt_q <= alarma_cnt_d;
        end
    end

    assign bus.estado     = estado_q;
    assign bus.restante   = restante_q;
    assign bus.calentando = calentando_q;
    assign bus.alarma     = alarma_q;
    assign bus.fin        = fin_q;

endmodule

// File: tb/tb_contador_regresivo.sv
module tb_contador_regresivo;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    contador_regresivo_if bus ();

    contador_regresivo #(.CLK_HZ(4), .ALARMA_S(3)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] num;
        logic       start;
        logic       pausa;
        logic       cancelar;
        logic [1:0] e_estado;
        logic [4:0] e_rest;
        logic       e_cal;
        logic       e_alarma;
        logic       e_fin;
    } vec_t;

    vec_t vecs[35];

    function automatic vec_t mk(input int n, input int s, input int p, input int c,
                                input int e, input int r, input int cal,
                                input int al, input int f);
        vec_t v;
        v.num      = 5'(n);
        v.start    = 1'(s);
        v.pausa    = 1'(p);
        v.cancelar = 1'(c);
        v.e_estado = 2'(e);
        v.e_rest   = 5'(r);
        v.e_cal    = 1'(cal);
        v.e_alarma = 1'(al);
        v.e_fin    = 1'(f);
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Apply inputs for one clock edge, then sample 1 time unit after it.
    task automatic drive(input int n, input int s, input int p, input int c);
        bus.num      = 5'(n);
        bus.start    = 1'(s);
        bus.pausa    = 1'(p);
        bus.cancelar = 1'(c);
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.pausa    = 1'b0;
        bus.cancelar = 1'b0;
    endtask

    task automatic idle(input int cycles);
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_all(input string tag, input int e, input int r, input int cal,
                             input int al, input int f);
        check({tag, " estado"}, int'(bus.estado), e);
        check({tag, " restante"}, int'(bus.restante), r);
        check({tag, " calentando"}, int'(bus.calentando), cal);
        check({tag, " alarma"}, int'(bus.alarma), al);
        check({tag, " fin"}, int'(bus.fin), f);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int alarm_cycles;
        int fin_seen;
        n_checks = 0;
        n_errors = 0;
        rst_n        = 1'b0;
        bus.num      = '0;
        bus.start    = 1'b0;
        bus.pausa    = 1'b0;
        bus.cancelar = 1'b0;

        //            num s p c | est rest cal al fin
        vecs[0]  = mk(0, 1, 0, 0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(7, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[2]  = mk(2, 1, 0, 0, 1, 2, 1, 0, 0);
        vecs[3]  = mk(9, 0, 0, 0, 1, 2, 1, 0, 0);
        vecs[4]  = mk(9, 1, 0, 0, 1, 2, 1, 0, 0);
        vecs[5]  = mk(9, 0, 1, 0, 2, 2, 0, 0, 0);
        vecs[6]  = mk(9, 0, 1, 0, 2, 2, 0, 0, 0);
        vecs[7]  = mk(9, 0, 0, 0, 2, 2, 0, 0, 0);
        vecs[8]  = mk(9, 1, 0, 0, 1, 2, 1, 0, 0);
        vecs[9]  = mk(0, 0, 0, 0, 1, 2, 1, 0, 0);
        vecs[10] = mk(0, 0, 0, 0, 1, 1, 1, 0, 0);
        vecs[11] = mk(0, 0, 0, 0, 1, 1, 1, 0, 0);
        vecs[12] = mk(0, 0, 0, 0, 1, 1, 1, 0, 0);
        vecs[13] = mk(0, 0, 0, 0, 1, 1, 1, 0, 0);
        vecs[14] = mk(0, 0, 0, 0, 3, 0, 0, 1, 1);
        vecs[15] = mk(4, 1, 0, 0, 3, 0, 0, 1, 0);
        vecs[16] = mk(0, 0, 1, 0, 3, 0, 0, 1, 0);
        vecs[17] = mk(0, 0, 0, 0, 3, 0, 0, 1, 0);
        vecs[18] = mk(0, 0, 0, 0, 3, 0, 0, 1, 0);
        vecs[19] = mk(0, 0, 0, 0, 3, 0, 0, 1, 0);
        vecs[20] = mk(0, 0, 0, 0, 3, 0, 0, 1, 0);
        vecs[21] = mk(0, 0, 0, 0, 3, 0, 0, 1, 0);
        vecs[22] = mk(0, 0, 0, 0, 3, 0, 0, 1, 0);
        vecs[23] = mk(0, 0, 0, 0, 3, 0, 0, 1, 0);
        vecs[24] = mk(0, 0, 0, 0, 3, 0, 0, 1, 0);
        vecs[25] = mk(0, 0, 0, 0, 3, 0, 0, 1, 0);
        vecs[26] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[27] = mk(3, 1, 0, 0, 1, 3, 1, 0, 0);
        vecs[28] = mk(3, 1, 1, 1, 0, 0, 0, 0, 0);
        vecs[29] = mk(1, 1, 0, 0, 1, 1, 1, 0, 0);
        vecs[30] = mk(0, 0, 0, 0, 1, 1, 1, 0, 0);
        vecs[31] = mk(0, 0, 0, 0, 1, 1, 1, 0, 0);
        vecs[32] = mk(0, 0, 0, 0, 1, 1, 1, 0, 0);
        vecs[33] = mk(0, 0, 0, 1, 0, 0, 0, 0, 0);
        vecs[34] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);

        #2;
        check_all("reset", 0, 0, 0, 0, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Table: one row per clock edge, starting from idle.
        for (int i = 0; i < 35; i++) begin
            drive(int'(vecs[i].num), int'(vecs[i].start), int'(vecs[i].pausa),
                  int'(vecs[i].cancelar));
            check_all($sformatf("vec%0d", i), int'(vecs[i].e_estado), int'(vecs[i].e_rest),
                      int'(vecs[i].e_cal), int'(vecs[i].e_alarma), int'(vecs[i].e_fin));
        end

        // Full run from 5 s: one decrement every 4 cycles, then 12-cycle alarm.
        drive(5, 1, 0, 0);
        check_all("run5 start", 1, 5, 1, 0, 0);
        for (int k = 1; k <= 5; k++) begin
            idle(3);
            check($sformatf("run5 hold%0d restante", k), int'(bus.restante), 6 - k);
            idle(1);
            check($sformatf("run5 tick%0d restante", k), int'(bus.restante), 5 - k);
        end
        check_all("run5 end", 3, 0, 0, 1, 1);
        alarm_cycles = 1;
        for (int k = 0; k < 40; k++) begin
            idle(1);
            if (bus.alarma) alarm_cycles++;
            else break;
        end
        check("run5 alarm cycles", alarm_cycles, 12);
        check_all("run5 idle", 0, 0, 0, 0, 0);

        // Pause two cycles into a second, hold, resume the partial second.
        drive(3, 1, 0, 0);
        check_all("pause start", 1, 3, 1, 0, 0);
        idle(2);
        drive(0, 0, 1, 0);
        check_all("pause enter", 2, 3, 0, 0, 0);
        for (int k = 0; k < 10; k++) begin
            idle(1);
            check($sformatf("pause hold%0d restante", k), int'(bus.restante), 3);
            check($sformatf("pause hold%0d estado", k), int'(bus.estado), 2);
        end
        drive(0, 1, 0, 0);
        check_all("resume", 1, 3, 1, 0, 0);
        idle(1);
        check("resume+1 restante", int'(bus.restante), 3);
        idle(1);
        check("resume+2 restante", int'(bus.restante), 2);

        // Pause on the tick edge: no decrement, then cancel at restante=2.
        idle(3);
        check("pre pausetick restante", int'(bus.restante), 2);
        drive(0, 0, 1, 0);
        check_all("pausa+tick", 2, 2, 0, 0, 0);
        drive(0, 1, 0, 0);
        check_all("resume2", 1, 2, 1, 0, 0);
        drive(0, 0, 0, 1);
        check_all("cancel r2", 0, 0, 0, 0, 0);
        fin_seen = 0;
        for (int k = 0; k < 8; k++) begin
            idle(1);
            if (bus.fin) fin_seen = 1;
        end
        check("cancel no fin", fin_seen, 0);
        check("cancel stays idle", int'(bus.estado), 0);

        // Asynchronous reset between clock edges mid-count.
        drive(4, 1, 0, 0);
        idle(5);
        check("prereset calentando", int'(bus.calentando), 1);
        #3;
        rst_n = 1'b0;
        #1;
        check_all("async reset", 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(6);
        check_all("post reset idle", 0, 0, 0, 0, 0);
        drive(1, 1, 0, 0);
        check_all("post reset start", 1, 1, 1, 0, 0);
        idle(3);
        check("post reset hold", int'(bus.restante), 1);
        idle(1);
        check_all("post reset fin", 3, 0, 0, 1, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
